spi_slave_if: RTL
=================

Name: spi_slave_if

Overview:
- Serial front end for the single-port SPI RAM.
- Deserialises MOSI frames into 10-bit command/data words and hands each word to the RAM with a one-cycle rx_valid pulse.
- For read-data frames, captures the RAM's tx_data and shifts it out on MISO, MSB first.
- Sits between the chip-level SPI pins and the RAM block. The whole slave runs on the SPI clock.

Parameters:
- ADDR_SIZE, 8, width of tx_data and of the serialised read word.
- FRAME_W, 10, bits per received frame: 2 command bits plus ADDR_SIZE payload bits.

Ports:
- clk  in  1  system/SPI clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- SS_n  in  1  slave select, active low; a frame is one low period.
- MOSI  in  1  serial data in, MSB first, sampled on the clk rising edge.
- MISO  out  1  serial read data out, MSB first.
- rx_data  out  FRAME_W  received frame; bits [9:8] are the command (00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data).
- rx_valid  out  1  one-cycle pulse; rx_data is valid while it is high.
- tx_data  in  ADDR_SIZE  read data from the RAM.
- tx_valid  in  1  RAM read-data-valid. It is sticky: it stays high after the first read.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - rx_data=0, rx_valid=0, MISO=0.
  - rd_addr_seen flag=0; bit counter=0; tx shift register=0.
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- IDLE: on an edge with SS_n=0, go to CHK_CMD. MOSI is ignored on that edge.
- CHK_CMD: the edge samples MOSI as frame bit 9.
  - MOSI=0 -> WRITE.
  - MOSI=1 and rd_addr_seen=0 -> READ_ADD.
  - MOSI=1 and rd_addr_seen=1 -> READ_DATA.
  - Counter=1 after this edge.
- WRITE / READ_ADD / READ_DATA: each edge shifts MOSI into the frame shift register, MSB first, and increments the counter.
  - On the edge that captures bit 0 (counter reaches FRAME_W), rx_data is loaded with the full frame and rx_valid=1 for exactly that next cycle.
  - No further shifting until SS_n rises.
  - The command bits are passed through unaltered; the slave does not police bit 8.
- rd_addr_seen:
  - Set when a READ_ADD frame completes its 10th bit.
  - Cleared when a READ_DATA frame completes its 10th bit.
  - Unchanged by aborted frames.
- READ_DATA transmit:
  - Armed after rx_valid.
  - The first edge after arming with tx_valid=1 loads tx_data into the tx shift register and drives MISO=tx_data[7].
  - The next 7 edges drive tx_data[6..0].
  - MISO then returns to 0.
  - Nominal timing, counting frame edges from the CHK_CMD edge as edge 1:
    - rx_valid high after edge 10.
    - RAM tx_valid high after edge 11.
    - MISO bit7 valid after edge 12 through bit0 after edge 19.
  - The stale sticky tx_valid before arming must not trigger a load.
- MISO is 0 whenever not transmitting.
- SS_n rising in any non-IDLE state: return to IDLE on that edge.
  - Counter and tx shift register are cleared; MISO=0.
  - No rx_valid is issued for an incomplete frame.
  - A pending transmit is aborted.
- SS_n held low after frame completion (non-read) or after the transmit completes: stay in state, idle outputs.
- Reset mid-frame: immediate return to reset values; the RAM contents are unaffected.

Decomposition:
- Package spi_pkg:
  - State enum.
  - Command localparams CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11.
  - FRAME_W.
- One sub-module, spi_tx_serializer: parallel-load, ADDR_SIZE-bit PISO with bit counter, load/busy/MISO. The FSM and frame deserialiser stay in spi_slave_if.

Test Plan:
- Reset with SS_n=1: rx_valid=0, MISO=0, rx_data=0. Assert rst_n low mid-READ_ADD frame -> IDLE at once, no rx_valid.
- Write-address frame 00_0001_0010 -> after edge 10: rx_data=10'h012, rx_valid high for 1 cycle, state WRITE until SS_n high.
- Write-data frame 01_1010_0101 -> rx_data=10'h1A5 with a 1-cycle pulse; rd_addr_seen stays 0.
- Read-address frame 10_0001_0010, then read-data frame 11_0000_0000 with the RAM model returning 8'hA5 -> first frame goes via READ_ADD, second via READ_DATA; MISO bits after edges 12-19 = 1,0,1,0,0,1,0,1; rd_addr_seen=0 afterwards.
- Second read-data attempt without a new read-address (MOSI first bit=1, rd_addr_seen=0) -> routed to READ_ADD. Sticky tx_valid=1 during that frame -> MISO stays 0.
- SS_n raised after 5 bits of a WRITE frame -> no rx_valid; the next full frame 00_1111_1111 yields rx_data=10'h0FF correctly.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave front end.
//   state_t  - frame FSM states
//   CMD_*    - command encodings carried in rx_data[9:8]
//   FRAME_W  - bits per received frame
package spi_pkg;

   localparam int FRAME_W = 10;

   localparam logic [1:0] CMD_WR_ADDR = 2'b00;
   localparam logic [1:0] CMD_WR_DATA = 2'b01;
   localparam logic [1:0] CMD_RD_ADDR = 2'b10;
   localparam logic [1:0] CMD_RD_DATA = 2'b11;

   typedef enum logic [2:0] {
      IDLE,
      CHK_CMD,
      WRITE,
      READ_ADD,
      READ_DATA
   } state_t;

endpackage

// File: rtl/spi_slave_if_if.sv
// Pin/RAM-side signal bundle for spi_slave_if.
//   SS_n, MOSI, MISO   - chip-level SPI pins
//   rx_data, rx_valid  - received frame towards the RAM
//   tx_data, tx_valid  - read data back from the RAM
// slave modport: the SPI slave; master modport: pins driver plus RAM.
interface spi_bus_if #(
   parameter int ADDR_SIZE = 8,
   parameter int FRAME_W   = spi_pkg::FRAME_W
);
   logic                 SS_n;
   logic                 MOSI;
   logic                 MISO;
   logic [FRAME_W-1:0]   rx_data;
   logic                 rx_valid;
   logic [ADDR_SIZE-1:0] tx_data;
   logic                 tx_valid;

   modport slave  (input  SS_n, MOSI, tx_data, tx_valid,
                   output MISO, rx_data, rx_valid);
   modport master (output SS_n, MOSI, tx_data, tx_valid,
                   input  MISO, rx_data, rx_valid);
endinterface

// File: rtl/spi_tx_serializer.sv
// Parallel-load shift-out of one read word, MSB first.
//   clk, rst_n - clock, async active-low reset
//   clear      - synchronous abort (slave deselected)
//   load       - capture din and drive its MSB on the same edge
//   din        - word to send
//   miso       - registered serial output, 0 when idle
//   busy       - word in flight (includes the return-to-0 edge)
module spi_tx_serializer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clear,
   input  logic         load,
   input  logic [W-1:0] din,
   output logic         miso,
   output logic         busy
);
   localparam int CW = $clog2(W);

   logic [W-1:0]  tx_sr;
   logic [CW-1:0] bits_left;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_sr     <= '0;
         bits_left <= '0;
         busy      <= 1'b0;
         miso      <= 1'b0;
      end else if (clear) begin
         tx_sr     <= '0;
         bits_left <= '0;
         busy      <= 1'b0;
         miso      <= 1'b0;
      end else if (load) begin
         // MSB goes straight to the pin; the rest waits in the register.
         miso      <= din[W-1];
         tx_sr     <= {din[W-2:0], 1'b0};
         bits_left <= CW'(W - 1);
         busy      <= 1'b1;
      end else if (busy) begin
         if (bits_left == '0) begin
            miso <= 1'b0;
            busy <= 1'b0;
         end else begin
            miso      <= tx_sr[W-1];
            tx_sr     <= {tx_sr[W-2:0], 1'b0};
            bits_left <= bits_left - 1'b1;
         end
      end
   end

endmodule

// File: rtl/spi_slave_if.sv
// SPI slave front end for the single-port SPI RAM.
// Deserialises MOSI frames into FRAME_W-bit words (pulse on rx_valid) and,
// for read-data frames, shifts the RAM's tx_data out on MISO.
//   clk, rst_n - SPI clock (rising edge), async active-low reset
//   bus        - spi_bus_if.slave: SS_n, MOSI, MISO, rx_data, rx_valid,
//                tx_data, tx_valid
module spi_slave_if #(
   parameter int ADDR_SIZE = 8,
   parameter int FRAME_W   = ADDR_SIZE + 2
) (
   input  logic     clk,
   input  logic     rst_n,
   spi_bus_if.slave bus
);
   import spi_pkg::*;

   localparam int CNT_W = $clog2(FRAME_W + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_W - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);

   state_t             state;
   logic [CNT_W-1:0]   bit_cnt;
   logic [FRAME_W-1:0] frame_sr;
   logic [FRAME_W-1:0] frame_next;
   logic               rd_addr_seen;
   logic               tx_armed;
   logic               tx_busy;
   logic               tx_load;
   logic               miso_q;

   assign frame_next = {frame_sr[FRAME_W-2:0], bus.MOSI};

   // Arming happens on the edge where rx_valid is already high, so a
   // tx_valid left high by an earlier read cannot load stale data before
   // the RAM has answered this frame.
   assign tx_load = (state == READ_DATA) && !bus.SS_n && tx_armed &&
                    bus.tx_valid && !tx_busy;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         bit_cnt      <= '0;
         frame_sr     <= '0;
         bus.rx_data  <= '0;
         bus.rx_valid <= 1'b0;
         rd_addr_seen <= 1'b0;
         tx_armed     <= 1'b0;
      end else begin
         bus.rx_valid <= 1'b0;
         if (state == IDLE) begin
            bit_cnt <= '0;
            if (!bus.SS_n) state <= CHK_CMD;
         end else if (bus.SS_n) begin
            // Frame ended (or aborted): drop everything, no rx_valid.
            state    <= IDLE;
            bit_cnt  <= '0;
            tx_armed <= 1'b0;
         end else begin
            case (state)
               CHK_CMD: begin
                  frame_sr <= FRAME_W'(bus.MOSI);
                  bit_cnt  <= CNT_W'(1);
                  if (!bus.MOSI)        state <= WRITE;
                  else if (rd_addr_seen) state <= READ_DATA;
                  else                   state <= READ_ADD;
               end
               default: begin
                  // Counter saturates at FRAME_W: extra bits are ignored.
                  if (bit_cnt != CNT_FULL) begin
                     frame_sr <= frame_next;
                     bit_cnt  <= bit_cnt + 1'b1;
                     if (bit_cnt == CNT_LAST) begin
                        bus.rx_data  <= frame_next;
                        bus.rx_valid <= 1'b1;
                        if (state == READ_ADD)       rd_addr_seen <= 1'b1;
                        else if (state == READ_DATA) rd_addr_seen <= 1'b0;
                     end
                  end
                  if (state == READ_DATA && bus.rx_valid) tx_armed <= 1'b1;
                  else if (tx_load)                       tx_armed <= 1'b0;
               end
            endcase
         end
      end
   end

   spi_tx_serializer #(.W(ADDR_SIZE)) u_tx (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (bus.SS_n),
      .load  (tx_load),
      .din   (bus.tx_data),
      .miso  (miso_q),
      .busy  (tx_busy)
   );

   assign bus.MISO = miso_q;

endmodule
